// File: rtl/inst_loader.sv
// inst_loader: boot-time writer for the CPU instruction memory.
//
// Receives a framed byte stream (LEN_LO, LEN_HI, then 4*LEN payload bytes,
// little-endian words) over a valid/ready handshake and writes each
// assembled word to consecutive word-aligned addresses starting at
// START_ADDR. CPU_HOLD keeps the CPU in reset until the image is complete.
//
// Optional feature: define INST_LOADER_CHECKSUM_EN to append a one-byte XOR
// checksum of the payload after the last word (also after a LEN==0 frame).
//
// Ports:
//   CLK         clock, rising edge
//   RST         asynchronous active-low reset
//   START       single-cycle load request (honoured in IDLE/DONE_S/ERR_S)
//   BYTE_IN     stream byte
//   BYTE_VALID  BYTE_IN valid
//   BYTE_READY  loader accepts a byte this cycle
//   MEM_WE      memory write enable, one cycle per word
//   MEM_ADDR    memory byte address (meaningful only with MEM_WE)
//   MEM_WD      memory write data (meaningful only with MEM_WE)
//   CPU_HOLD    1 = hold CPU in reset
//   DONE        image loaded successfully
//   ERR         frame error
//   WORD_CNT    words written in the current load
module inst_loader #(
    parameter int          ADDR_W     = 8,
    parameter int          MAX_WORDS  = 256,
    parameter int unsigned START_ADDR = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [7:0]        BYTE_IN,
    input  logic              BYTE_VALID,
    output logic              BYTE_READY,
    output logic              MEM_WE,
    output logic [31:0]       MEM_ADDR,
    output logic [31:0]       MEM_WD,
    output logic              CPU_HOLD,
    output logic              DONE,
    output logic              ERR,
    output logic [ADDR_W:0]   WORD_CNT
);

`ifdef INST_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE_S, ERR_S, CHK} state_t;
`else
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE_S, ERR_S} state_t;
`endif

    state_t          state_q, state_d;
    logic [15:0]     len_q;
    logic [1:0]      byte_cnt_q;
    logic [31:0]     asm_q;
    logic [ADDR_W:0] idx_q;
    logic [ADDR_W:0] word_cnt_q;
    logic            mem_we_q;
    logic [ADDR_W:0] idx_nxt;
    logic [15:0]     len_full;
    logic            accept;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]      xor_q;
`endif

    assign idx_nxt  = idx_q + 1'b1;
    // Full length as seen while LEN_HI is being accepted.
    assign len_full = {BYTE_IN, len_q[7:0]};
    assign accept   = BYTE_VALID & BYTE_READY;

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (START) state_d = LEN_LO;
            LEN_LO: if (BYTE_VALID) state_d = LEN_HI;
            LEN_HI: if (BYTE_VALID) begin
`ifdef INST_LOADER_CHECKSUM_EN
                if (len_full == 16'd0)                   state_d = CHK;
`else
                if (len_full == 16'd0)                   state_d = DONE_S;
`endif
                else if (len_full > 16'(MAX_WORDS))      state_d = ERR_S;
                else                                     state_d = DATA;
            end
            DATA:   if (BYTE_VALID && byte_cnt_q == 2'd3) state_d = WRITE;
            WRITE: begin
`ifdef INST_LOADER_CHECKSUM_EN
                if (16'(idx_nxt) == len_q) state_d = CHK;
`else
                if (16'(idx_nxt) == len_q) state_d = DONE_S;
`endif
                else                       state_d = DATA;
            end
`ifdef INST_LOADER_CHECKSUM_EN
            CHK:    if (BYTE_VALID) state_d = (BYTE_IN == xor_q) ? DONE_S : ERR_S;
`endif
            DONE_S: if (START) state_d = LEN_LO;
            ERR_S:  if (START) state_d = LEN_LO;
            default: state_d = IDLE;
        endcase
    end

    // Output decode (Moore)
    always_comb begin
        BYTE_READY = 1'b0;
        DONE       = 1'b0;
        ERR        = 1'b0;
        CPU_HOLD   = 1'b1;
        case (state_q)
            LEN_LO, LEN_HI, DATA: BYTE_READY = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
            CHK:                  BYTE_READY = 1'b1;
`endif
            DONE_S: begin DONE = 1'b1; CPU_HOLD = 1'b0; end
            ERR_S:  ERR  = 1'b1;
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            len_q      <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            idx_q      <= '0;
            word_cnt_q <= '0;
            mem_we_q   <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            xor_q      <= '0;
`endif
        end else begin
            // Registered so MEM_WE is high for exactly the WRITE cycle.
            mem_we_q <= (state_d == WRITE);
            case (state_q)
                IDLE, DONE_S, ERR_S: if (START) begin
                    word_cnt_q <= '0;
                    idx_q      <= '0;
                    byte_cnt_q <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
                    xor_q      <= '0;
`endif
                end
                LEN_LO: if (accept) len_q[7:0] <= BYTE_IN;
                LEN_HI: if (accept) begin
                    len_q[15:8] <= BYTE_IN;
                    byte_cnt_q  <= '0;
                    idx_q       <= '0;
                end
                DATA: if (accept) begin
                    asm_q[{byte_cnt_q, 3'b000} +: 8] <= BYTE_IN;
                    byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
                    xor_q      <= xor_q ^ BYTE_IN;
`endif
                end
                WRITE: begin
                    idx_q      <= idx_nxt;
                    word_cnt_q <= word_cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign MEM_WE   = mem_we_q;
    assign MEM_WD   = asm_q;
    assign MEM_ADDR = START_ADDR + (32'(idx_q) << 2);
    assign WORD_CNT = word_cnt_q;

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [7:0]  BYTE_IN = 8'h00;
    logic        BYTE_VALID = 1'b0;
    logic        BYTE_READY;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WD;
    logic        CPU_HOLD;
    logic        DONE;
    logic        ERR;
    logic [8:0]  WORD_CNT;

    int checks = 0;
    int fails  = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    inst_loader dut (
        .CLK(CLK), .RST(RST), .START(START), .BYTE_IN(BYTE_IN),
        .BYTE_VALID(BYTE_VALID), .BYTE_READY(BYTE_READY), .MEM_WE(MEM_WE),
        .MEM_ADDR(MEM_ADDR), .MEM_WD(MEM_WD), .CPU_HOLD(CPU_HOLD),
        .DONE(DONE), .ERR(ERR), .WORD_CNT(WORD_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Write monitor: capture every write; the loader must not be ready then.
    always @(negedge CLK) begin
        if (MEM_WE === 1'b1) begin
            wa_q.push_back(MEM_ADDR);
            wd_q.push_back(MEM_WD);
            checks++;
            if (BYTE_READY !== 1'b0) begin
                fails++;
                $display("FAIL ready_in_write: got %b expected 0", BYTE_READY);
            end
        end
    end

    typedef struct {
        int               nb;
        logic [0:15][7:0] b;
        bit               tog;
        int               nw;
        logic [0:3][31:0] ea;
        logic [0:3][31:0] ed;
        logic             done;
        logic             err;
        logic [8:0]       cnt;
    } vec_t;

    vec_t v[8];
    int   nv;

    // Called at a negedge; returns at a negedge after the byte was consumed.
    task automatic send(input logic [7:0] b, input bit tog, output bit ok);
        int n = 0;
        if (tog) begin
            BYTE_VALID = 1'b0;
            @(posedge CLK); @(negedge CLK);
        end
        BYTE_IN = b;
        BYTE_VALID = 1'b1;
        while (BYTE_READY !== 1'b1 && n < 20) begin
            @(posedge CLK); @(negedge CLK); n++;
        end
        ok = (BYTE_READY === 1'b1);
        if (ok) begin
            @(posedge CLK); @(negedge CLK);
        end
        BYTE_VALID = 1'b0;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        @(posedge CLK); @(negedge CLK);
        START = 1'b0;
    endtask

    initial begin
        bit ok;
        vec_t t;
        nv = 0;

        // Two-word frame from the boot program.
        t = '{nb: 10, b: {8'h02,8'h00,8'h13,8'h05,8'hA0,8'h00,8'h93,8'h05,8'hB0,8'h00,
                          8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
              tog: 0, nw: 2, ea: {32'h0,32'h4,32'h0,32'h0},
              ed: {32'h00A00513,32'h00B00593,32'h0,32'h0},
              done: 1, err: 0, cnt: 9'd2};
`ifdef INST_LOADER_CHECKSUM_EN
        // 13^05^A0^00 ^ 93^05^B0^00 = B6 ^ 26 = 90
        t.nb = 11; t.b[10] = 8'h90;
`endif
        v[nv++] = t;
        t.tog = 1;
        v[nv++] = t;
        // LEN = 513 > MAX_WORDS
        t = '{nb: 2, b: '0, tog: 0, nw: 0, ea: '0, ed: '0, done: 0, err: 1, cnt: 9'd0};
        t.b[0] = 8'h01; t.b[1] = 8'h02;
        v[nv++] = t;
        // One word after an error.
        t = '{nb: 6, b: {8'h01,8'h00,8'h13,8'h05,8'hA0,8'h00,8'h00,8'h00,
                         8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
              tog: 0, nw: 1, ea: '0, ed: {32'h00A00513,32'h0,32'h0,32'h0},
              done: 1, err: 0, cnt: 9'd1};
`ifdef INST_LOADER_CHECKSUM_EN
        t.nb = 7; t.b[6] = 8'hB6;
`endif
        v[nv++] = t;
`ifdef INST_LOADER_CHECKSUM_EN
        // Bad checksum: word stays written, load errors.
        t.b[6] = 8'h00; t.done = 0; t.err = 1;
        v[nv++] = t;
`endif
        // LEN = 257: one past the limit.
        t = '{nb: 2, b: '0, tog: 0, nw: 0, ea: '0, ed: '0, done: 0, err: 1, cnt: 9'd0};
        t.b[0] = 8'h01; t.b[1] = 8'h01;
        v[nv++] = t;
        // LEN = 0 completes with no writes.
        t = '{nb: 2, b: '0, tog: 0, nw: 0, ea: '0, ed: '0, done: 1, err: 0, cnt: 9'd0};
`ifdef INST_LOADER_CHECKSUM_EN
        t.nb = 3;
`endif
        v[nv++] = t;
        // Three words: address increments to 0x08.
        t = '{nb: 14, b: {8'h03,8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,
                          8'h07,8'h08,8'h09,8'h0A,8'h0B,8'h0C,8'h00,8'h00},
              tog: 0, nw: 3, ea: {32'h0,32'h4,32'h8,32'h0},
              ed: {32'h04030201,32'h08070605,32'h0C0B0A09,32'h0},
              done: 1, err: 0, cnt: 9'd3};
`ifdef INST_LOADER_CHECKSUM_EN
        // XOR of 01..0C = 0C
        t.nb = 15; t.b[14] = 8'h0C;
`endif
        v[nv++] = t;

        // Reset state.
        repeat (3) @(negedge CLK);
        chk("rst_hold",  32'(CPU_HOLD),   32'd1);
        chk("rst_ready", 32'(BYTE_READY), 32'd0);
        chk("rst_we",    32'(MEM_WE),     32'd0);
        chk("rst_done",  32'(DONE),       32'd0);
        chk("rst_err",   32'(ERR),        32'd0);
        RST = 1'b1;
        @(negedge CLK);
        chk("idle_ready", 32'(BYTE_READY), 32'd0);
        chk("idle_hold",  32'(CPU_HOLD),   32'd1);

        for (int i = 0; i < nv; i++) begin
            wa_q.delete(); wd_q.delete();
            pulse_start();
            chk($sformatf("v%0d_start_ready", i), 32'(BYTE_READY), 32'd1);
            chk($sformatf("v%0d_start_hold",  i), 32'(CPU_HOLD),   32'd1);
            chk($sformatf("v%0d_start_done",  i), 32'(DONE),       32'd0);
            chk($sformatf("v%0d_start_err",   i), 32'(ERR),        32'd0);
            for (int k = 0; k < v[i].nb; k++) begin
                send(v[i].b[k], v[i].tog, ok);
                if (!ok) begin
                    chk($sformatf("v%0d_hs_timeout_b%0d", i, k), 32'(ok), 32'd1);
                    break;
                end
            end
            repeat (3) @(negedge CLK);
            chk($sformatf("v%0d_nwrites", i), 32'(wa_q.size()), 32'(v[i].nw));
            for (int k = 0; k < v[i].nw && k < wa_q.size(); k++) begin
                chk($sformatf("v%0d_addr%0d", i, k), wa_q[k], v[i].ea[k]);
                chk($sformatf("v%0d_data%0d", i, k), wd_q[k], v[i].ed[k]);
            end
            chk($sformatf("v%0d_done",  i), 32'(DONE),       32'(v[i].done));
            chk($sformatf("v%0d_err",   i), 32'(ERR),        32'(v[i].err));
            chk($sformatf("v%0d_hold",  i), 32'(CPU_HOLD),   32'(!v[i].done));
            chk($sformatf("v%0d_cnt",   i), 32'(WORD_CNT),   32'(v[i].cnt));
            chk($sformatf("v%0d_ready", i), 32'(BYTE_READY), 32'd0);
        end

        // Reset mid-load after 3 payload bytes: abort with no write.
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send(8'h02, 0, ok); send(8'h00, 0, ok);
        send(8'h13, 0, ok); send(8'h05, 0, ok); send(8'hA0, 0, ok);
        chk("abort_ready_before", 32'(BYTE_READY), 32'd1);
        BYTE_IN = 8'h00; BYTE_VALID = 1'b1;
        #1 RST = 1'b0;
        #1;
        chk("abort_hold",  32'(CPU_HOLD),   32'd1);
        chk("abort_ready", 32'(BYTE_READY), 32'd0);
        chk("abort_cnt",   32'(WORD_CNT),   32'd0);
        chk("abort_done",  32'(DONE),       32'd0);
        chk("abort_we",    32'(MEM_WE),     32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (6) @(negedge CLK);
        BYTE_VALID = 1'b0;
        chk("abort_nwrites", 32'(wa_q.size()), 32'd0);
        chk("abort_idle_ready", 32'(BYTE_READY), 32'd0);
        chk("abort_idle_hold",  32'(CPU_HOLD),   32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
